// File: rtl/pwm_counter.sv
// Free-running N-bit period counter with synchronous clear and a wrap strobe.
// wrap is high during the cycle in which the counter holds its terminal value
// while enabled, i.e. the edge that ends the current period.
module pwm_counter #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         clear,
  output logic [N-1:0] cnt,
  output logic         wrap
);

  localparam logic [N-1:0] CntMax = {N{1'b1}};

  // Count while enabled; clear has priority so an idle channel restarts at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (ena) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Terminal-count strobe; only meaningful while counting.
  always_comb begin
    wrap = ena && !clear && (cnt == CntMax);
  end

endmodule

// File: rtl/pwm.sv
// Single-channel PWM. The output is high for duty_q cycles at the start of
// every 2^N-cycle period. duty is captured into duty_q only at period
// boundaries (or continuously while idle) so a period never mixes two duties.
module pwm #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] duty,
  output logic         out
);

  logic [N-1:0] cnt;
  logic [N-1:0] duty_q;
  logic         wrap;

  pwm_counter #(
    .N (N)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .clear (!ena),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  // Shadow duty and registered compare; out lags cnt by one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      duty_q <= '0;
      out    <= 1'b0;
    end else if (!ena) begin
      // Track duty while idle so the first enabled period uses the live value.
      duty_q <= duty;
      out    <= 1'b0;
    end else begin
      out <= (cnt < duty_q);
      if (wrap) begin
        duty_q <= duty;
      end
    end
  end

endmodule

// File: tb/tb_pwm.sv
// Directed bench for pwm at N=4 (16-cycle periods). Out is sampled 1 time unit
// after each rising edge; inputs change on falling edges or right after a sample.
module tb_pwm;

  localparam int unsigned N = 4;

  logic         clk;
  logic         rst;
  logic         ena;
  logic [N-1:0] duty;
  logic         out;

  int n_cmp;
  int n_bad;

  pwm #(
    .N (N)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .duty (duty),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected waveform of one period with h high cycles starting at bit 0.
  function automatic logic [15:0] mask(input int h);
    logic [15:0] one;
    one = 16'd1;
    return (one << h) - 16'd1;
  endfunction

  // Capture n samples of out; after sample chg_at (if >= 0) drive duty = nxt.
  task automatic grab(input int n, input int chg_at, input int nxt, output logic [15:0] w);
    w = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      w[i] = out;
      if (i == chg_at) duty = N'(nxt);
    end
  endtask

  // One reset cycle, then release so the next edge processes cnt = 0.
  task automatic do_reset(input logic ena_v, input int duty_v);
    @(negedge clk);
    rst  = 1'b0;
    ena  = ena_v;
    duty = N'(duty_v);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [15:0] w;
    int          cur;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    ena   = 1'b0;
    duty  = '0;

    // Reset held 3 cycles with ena=1, duty=5: out stays low.
    @(negedge clk);
    ena  = 1'b1;
    duty = 4'd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("reset_out", out, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    grab(16, -1, 0, w);
    check_eq("post_reset_p0", w, 16'h0000);
    grab(16, -1, 0, w);
    check_eq("post_reset_p1", w, 16'h001F);

    // Duty sweep 0..15, two periods each; duty written during the prior period.
    do_reset(1'b1, 0);
    cur = 0;
    for (int d = 0; d < 16; d++) begin
      for (int rep = 0; rep < 2; rep++) begin
        grab(16, 0, d, w);
        check_eq($sformatf("sweep_d%0d_r%0d", cur, rep), w, mask(cur));
        cur = d;
      end
    end
    grab(16, -1, 0, w);
    check_eq("sweep_d15_last", w, 16'h7FFF);

    // Mid-period change 12 -> 3 has no effect until the wrap.
    do_reset(1'b1, 12);
    grab(16, -1, 0, w);
    check_eq("mid_p0", w, 16'h0000);
    grab(16, 5, 3, w);
    check_eq("mid_p1_12", w, 16'h0FFF);
    grab(16, -1, 0, w);
    check_eq("mid_p2_3", w, 16'h0007);

    // Enable from idle with duty=8.
    do_reset(1'b0, 8);
    grab(3, -1, 0, w);
    check_eq("idle_low", w, 16'h0000);
    @(negedge clk);
    ena = 1'b1;
    grab(16, -1, 0, w);
    check_eq("enable_p0", w, 16'h00FF);
    grab(16, -1, 0, w);
    check_eq("enable_p1", w, 16'h00FF);

    // Disable at cnt=4, stay idle, then re-enable for a fresh 10/6 period.
    do_reset(1'b1, 10);
    grab(16, -1, 0, w);
    check_eq("dis_p0", w, 16'h0000);
    grab(4, -1, 0, w);
    check_eq("dis_head", w, 16'h000F);
    @(negedge clk);
    ena = 1'b0;
    grab(5, -1, 0, w);
    check_eq("dis_idle", w, 16'h0000);
    @(negedge clk);
    ena = 1'b1;
    grab(16, -1, 0, w);
    check_eq("dis_reenable", w, 16'h03FF);

    // Reset pulse at cnt=7.
    do_reset(1'b1, 10);
    grab(16, -1, 0, w);
    check_eq("rst_mid_p0", w, 16'h0000);
    grab(7, -1, 0, w);
    check_eq("rst_mid_head", w, 16'h007F);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_mid_out", out, 0);
    check_eq("rst_mid_cnt", 32'(dut.cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    grab(16, -1, 0, w);
    check_eq("rst_mid_p1", w, 16'h0000);
    grab(16, -1, 0, w);
    check_eq("rst_mid_p2", w, 16'h03FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
